data_pack_datapath: RTL and testbench

//   Transmit-side packer. Accepts PACKET_SIZE-bit packets over valid/ready and packs them
//   LSB-first, with no gaps, into DATA_SIZE-bit words. Packets may straddle word boundaries.

---
 rtl/data_pack_datapath.sv | 156 +++++++++++++++
 tb/tb_data_pack_datapath.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_pack_datapath.sv
// -----------------------------------------------------------------------------
// data_pack_datapath
//   Transmit-side packer. PACKET_SIZE-bit packets arrive over valid/ready and
//   are packed LSB-first, with no gaps, into DATA_SIZE-bit words. A packet may
//   straddle two words. A flush request drains any partial word, zero-padded in
//   the upper bits, and then pulses flush_done for one cycle.
//
// Ports
//   clk         in   1                 rising-edge clock
//   rst_n       in   1                 synchronous active-low reset
//   pkt_in      in   PACKET_SIZE       packet data
//   pkt_valid   in   1                 pkt_in is valid
//   pkt_ready   out  1                 packer accepts a packet this cycle
//   flush       in   1                 request to drain the partial word
//   word_out    out  DATA_SIZE         packed word (registered)
//   word_valid  out  1                 word_out is valid
//   word_ready  in   1                 downstream consumes word_out
//   flush_done  out  1                 one-cycle pulse when a flush completes
//   fill_level  out  DATA_BITWIDTH+1   bits currently held in the accumulator
// -----------------------------------------------------------------------------
module data_pack_datapath #(
    parameter int DATA_BITWIDTH = 5,
    parameter int PACKET_SIZE   = 7,
    localparam int DATA_SIZE    = 2 ** DATA_BITWIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [PACKET_SIZE-1:0]   pkt_in,
    input  logic                     pkt_valid,
    output logic                     pkt_ready,
    input  logic                     flush,
    output logic [DATA_SIZE-1:0]     word_out,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic                     flush_done,
    output logic [DATA_BITWIDTH:0]   fill_level
);

    localparam int ACC_W  = DATA_SIZE + PACKET_SIZE - 1;
    localparam int FILL_W = DATA_BITWIDTH + 1;
    localparam logic [FILL_W-1:0] WORD_BITS = FILL_W'(DATA_SIZE);
    localparam logic [FILL_W-1:0] PKT_BITS  = FILL_W'(PACKET_SIZE);
    localparam logic [FILL_W-1:0] FILL_ZERO = {FILL_W{1'b0}};

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                 state_r, state_s;
    logic [ACC_W-1:0]       acc_r, acc_s;
    logic [FILL_W-1:0]      fill_r, fill_s;
    logic [DATA_SIZE-1:0]   word_r, word_s;
    logic                   wvalid_r, wvalid_s;
    logic                   done_r, done_s;

    logic                   pkt_ready_s;
    logic                   accept_s;
    logic                   slot_free_s;
    logic                   load_full_s;
    logic                   load_part_s;
    logic [ACC_W-1:0]       pkt_ext_s;

    // Handshake qualifiers. pkt_ready is low whenever a full word is held, so
    // an accept and a word load can never coincide.
    always_comb begin
        pkt_ready_s = (state_r == ST_FILL) && (fill_r < WORD_BITS);
        accept_s    = pkt_valid && pkt_ready_s;
        slot_free_s = !wvalid_r || word_ready;
        load_full_s = (fill_r >= WORD_BITS) && slot_free_s;
        load_part_s = (state_r == ST_FLUSH) && (fill_r != FILL_ZERO) &&
                      (fill_r < WORD_BITS) && slot_free_s;
        pkt_ext_s   = {{(ACC_W - PACKET_SIZE){1'b0}}, pkt_in};
    end

    // Accumulator and output word next-state. Bits of acc at or above fill are
    // always zero, so OR-ing the shifted packet places it and a partial drain
    // is already zero-padded.
    always_comb begin
        acc_s    = acc_r;
        fill_s   = fill_r;
        word_s   = word_r;
        wvalid_s = wvalid_r && !word_ready;
        if (load_full_s) begin
            word_s   = acc_r[DATA_SIZE-1:0];
            wvalid_s = 1'b1;
            acc_s    = acc_r >> DATA_SIZE;
            fill_s   = fill_r - WORD_BITS;
        end else if (load_part_s) begin
            word_s   = acc_r[DATA_SIZE-1:0];
            wvalid_s = 1'b1;
            acc_s    = {ACC_W{1'b0}};
            fill_s   = FILL_ZERO;
        end else if (accept_s) begin
            acc_s    = acc_r | (pkt_ext_s << fill_r);
            fill_s   = fill_r + PKT_BITS;
        end else begin
            acc_s    = acc_r;
            fill_s   = fill_r;
        end
    end

    // FILL/FLUSH control. A packet accepted in the cycle flush is seen is
    // already counted in fill, so it is drained with the flush.
    always_comb begin
        state_s = state_r;
        done_s  = 1'b0;
        case (state_r)
            ST_FILL: begin
                if (flush) begin
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_FILL;
                end
            end
            ST_FLUSH: begin
                if (fill_r == FILL_ZERO) begin
                    state_s = ST_FILL;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            default: begin
                state_s = ST_FILL;
                done_s  = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r  <= ST_FILL;
            acc_r    <= {ACC_W{1'b0}};
            fill_r   <= FILL_ZERO;
            word_r   <= {DATA_SIZE{1'b0}};
            wvalid_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            acc_r    <= acc_s;
            fill_r   <= fill_s;
            word_r   <= word_s;
            wvalid_r <= wvalid_s;
            done_r   <= done_s;
        end
    end

    assign pkt_ready  = pkt_ready_s;
    assign word_out   = word_r;
    assign word_valid = wvalid_r;
    assign flush_done = done_r;
    assign fill_level = fill_r;

endmodule

// File: tb/tb_data_pack_datapath.sv
// -----------------------------------------------------------------------------
// tb_data_pack_datapath
//   Scoreboard bench for data_pack_datapath. The reference model keeps a plain
//   queue of bits: accepted packets append 7 bits, every 32 bits become an
//   expected word, and a flush pads what is left with zeros. A separate output
//   monitor pops and compares whenever a word is handed off.
// -----------------------------------------------------------------------------
module tb_data_pack_datapath;

    localparam int DW = 5;
    localparam int PS = 7;
    localparam int DS = 32;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [PS-1:0]   pkt_in = '0;
    logic            pkt_valid = 1'b0;
    logic            pkt_ready;
    logic            flush = 1'b0;
    logic [DS-1:0]   word_out;
    logic            word_valid;
    logic            word_ready = 1'b0;
    logic            flush_done;
    logic [DW:0]     fill_level;

    data_pack_datapath #(.DATA_BITWIDTH(DW), .PACKET_SIZE(PS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pkt_in     (pkt_in),
        .pkt_valid  (pkt_valid),
        .pkt_ready  (pkt_ready),
        .flush      (flush),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .flush_done (flush_done),
        .fill_level (fill_level)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [DS-1:0] exp_q[$];
    bit          model_bits[$];
    int          pending_done = 0;
    bit          flush_busy = 0;
    int          flush_cyc = 0;
    int          exp_done_lat = 0;
    bit          prev_hold = 0;
    logic [DS-1:0] prev_word = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: bit queue, LSB first.
    task automatic model_pkt(input logic [PS-1:0] p);
        logic [DS-1:0] w;
        for (int i = 0; i < PS; i++) model_bits.push_back(p[i]);
        while (model_bits.size() >= DS) begin
            w = '0;
            for (int i = 0; i < DS; i++) w[i] = model_bits.pop_front();
            exp_q.push_back(w);
        end
    endtask

    task automatic model_flush();
        logic [DS-1:0] w;
        if (model_bits.size() > 0) begin
            w = '0;
            for (int i = 0; i < model_bits.size(); i++) w[i] = model_bits[i];
            model_bits.delete();
            exp_q.push_back(w);
        end
    endtask

    // Input monitor: records what the DUT will act on at the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush_busy && !flush_done) check("pkt_ready_in_flush", pkt_ready, 1'b0);
            if (pkt_valid && pkt_ready) model_pkt(pkt_in);
            if (flush && !flush_busy) begin
                flush_busy = 1;
                model_flush();
                pending_done++;
                flush_cyc = cyc;
            end
        end
    end

    // Output monitor: handshake stability, word scoreboard, flush_done.
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_hold) begin
                check("hold_valid", word_valid, 1'b1);
                check("hold_word", word_out, prev_word);
            end
            if (word_valid && word_ready) begin
                check("word_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) check("word", word_out, exp_q.pop_front());
            end
            if (flush_done) begin
                check("flush_done_expected", pending_done > 0, 1'b1);
                if (pending_done > 0) begin
                    pending_done--;
                    flush_busy = 0;
                    if (exp_done_lat != 0) check("flush_done_latency", cyc - flush_cyc, exp_done_lat);
                end
            end
            prev_hold = word_valid && !word_ready;
            prev_word = word_out;
        end else begin
            prev_hold = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pkt_valid = 1'b0;
        flush = 1'b0;
        word_ready = 1'b0;
        exp_q.delete();
        model_bits.delete();
        pending_done = 0;
        flush_busy = 0;
        exp_done_lat = 0;
        step();
        check("rst_word_valid", word_valid, 1'b0);
        check("rst_word_out", word_out, 32'h0);
        check("rst_fill_level", fill_level, 6'd0);
        check("rst_flush_done", flush_done, 1'b0);
        check("rst_pkt_ready", pkt_ready, 1'b1);
        check("rst_no_x", $isunknown({word_valid, word_out, fill_level, flush_done, pkt_ready}), 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic send(input logic [PS-1:0] p);
        bit ok;
        ok = 0;
        pkt_valid = 1'b1;
        pkt_in = p;
        for (int t = 0; t < 200; t++) begin
            if (pkt_ready) begin
                step();
                ok = 1;
                break;
            end
            step();
        end
        pkt_valid = 1'b0;
        if (!ok) check("send_timeout", ok, 1'b1);
    endtask

    task automatic flush_wait();
        int t;
        flush = 1'b1;
        step();
        flush = 1'b0;
        t = 0;
        while (flush_busy && t < 60) begin
            step();
            t++;
        end
        check("flush_timeout", flush_busy, 1'b0);
    endtask

    task automatic drain();
        word_ready = 1'b1;
        pkt_valid = 1'b0;
        repeat (6) step();
        check("fill_level", fill_level, model_bits.size());
        check("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int acc_cnt;
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cnt;
        step();
        do_reset();

        // 1: packets 0..31 back to back
        word_ready = 1'b1;
        for (int i = 0; i < 32; i++) send(7'(i));
        drain();

        // 2: all ones, exact multiple of the word width
        for (int i = 0; i < 32; i++) send(7'h7F);
        drain();

        // 3: partial word on flush, flush_done the cycle after the word loads
        for (int i = 0; i < 3; i++) send(7'h7F);
        exp_done_lat = 3;
        flush_wait();
        drain();

        // 5a: empty flush, no word, flush_done two cycles after flush
        exp_done_lat = 2;
        flush_wait();
        drain();

        // 5b: flush in the same cycle as an accept
        exp_done_lat = 3;
        pkt_valid = 1'b1;
        pkt_in = 7'($urandom);
        flush = 1'b1;
        step();
        pkt_valid = 1'b0;
        flush = 1'b0;
        for (int t = 0; t < 60 && flush_busy; t++) step();
        check("flush_timeout_5b", flush_busy, 1'b0);
        exp_done_lat = 0;
        drain();

        // 4: backpressure with a continuous 0x55 stream
        word_ready = 1'b0;
        pkt_in = 7'h55;
        pkt_valid = 1'b1;
        acc_cnt = 0;
        for (int t = 0; t < 30; t++) begin
            if (pkt_ready) acc_cnt++;
            step();
        end
        check("stall_accepts", acc_cnt, 10);
        check("stall_fill", fill_level, 6'd38);
        check("stall_pkt_ready", pkt_ready, 1'b0);
        check("stall_word_valid", word_valid, 1'b1);
        word_ready = 1'b1;
        for (int i = 0; i < 12; i++) send(7'h55);
        drain();
        flush_wait();
        drain();

        // 6: reset mid-word with a word held
        word_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(7'($urandom));
        check("pre_reset_fill", fill_level, 6'd24);
        check("pre_reset_valid", word_valid, 1'b1);
        do_reset();
        word_ready = 1'b1;
        send(7'h2A);
        check("post_reset_fill", fill_level, 6'd7);
        flush_wait();
        drain();

        // Random traffic with backpressure and occasional flushes
        for (int t = 0; t < 3000; t++) begin
            pkt_valid  = ($urandom % 4) != 0;
            pkt_in     = 7'($urandom);
            word_ready = ($urandom % 3) != 0;
            flush      = (!flush_busy && ($urandom % 50) == 0);
            step();
        end
        pkt_valid = 1'b0;
        flush = 1'b0;
        word_ready = 1'b1;
        for (int t = 0; t < 60 && flush_busy; t++) step();
        check("random_flush_timeout", flush_busy, 1'b0);
        drain();
        flush_wait();
        drain();
        check("pending_done", pending_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
